// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over AXI4-Lite AR/R,
// hands {pc, inst, err} to decode, then waits for the next-PC update from write-back.
module ysyx_24080014_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_err,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_pc
);

    typedef enum logic [2:0] {
        S_RST,
        S_AR,
        S_R,
        S_OUT,
        S_WAIT
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // The PC is frozen from S_AR until the update in S_WAIT, so it doubles as the
    // stable fetch address and the delivered PC.
    assign ARADDR = pc;
    assign out_pc = pc;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= S_RST;
            pc        <= RESET_PC;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_inst  <= 32'h0;
            upd_ready <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    state   <= S_AR;
                    ARVALID <= (pc[1:0] == 2'b00);
                end
                S_AR: begin
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned PC: report an error without touching the bus.
                        ARVALID   <= 1'b0;
                        out_inst  <= 32'h0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (RVALID && RREADY) begin
                        RREADY    <= 1'b0;
                        out_inst  <= (RRESP == 2'b00) ? RDATA : 32'h0;
                        out_err   <= (RRESP != 2'b00);
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        upd_ready <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (upd_valid) begin
                        pc        <= upd_pc;
                        upd_ready <= 1'b0;
                        ARVALID   <= (upd_pc[1:0] == 2'b00);
                        state     <= S_AR;
                    end
                end
                default: begin
                    state     <= S_RST;
                    ARVALID   <= 1'b0;
                    RREADY    <= 1'b0;
                    out_valid <= 1'b0;
                    upd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Directed bench for the IFU: drives the AXI slave side, decode and write-back by hand
// and checks each output against hand-computed values one cycle at a time.
module tb_ysyx_24080014_ifu;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] ARADDR;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [31:0] RDATA = 32'h0;
    logic [1:0]  RRESP = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_pc = 32'h0;

    int total = 0;
    int bad = 0;

    ysyx_24080014_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_err(out_err),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc)
    );

    always #5 ACLK = ~ACLK;

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) tick();
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b exp=0", ARVALID); end
        total++; if (RREADY !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b exp=0", RREADY); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rst_upd_ready got=%b exp=0", upd_ready); end
        total++; if (out_err !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("FAIL rst_out_data got err=%b inst=%h exp err=0 inst=0", out_err, out_inst); end
        ARESETn = 1'b1;
        #1;
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL rel_idle_arvalid got=%b exp=0", ARVALID); end
        tick();
        total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0000) begin bad++; $display("FAIL first_ar got v=%b a=%h exp v=1 a=80000000", ARVALID, ARADDR); end
    endtask

    task automatic test_fetch_wait();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0000) begin bad++; $display("FAIL ar_hold%0d got v=%b a=%h exp v=1 a=80000000", i, ARVALID, ARADDR); end
        end
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        total++; if (ARVALID !== 1'b0 || RREADY !== 1'b1) begin bad++; $display("FAIL ar_done got arv=%b rr=%b exp arv=0 rr=1", ARVALID, RREADY); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (RREADY !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL r_wait%0d got rr=%b ov=%b exp rr=1 ov=0", i, RREADY, out_valid); end
        end
        RVALID = 1'b1; RDATA = 32'h0000_0413; RRESP = 2'b00;
        tick();
        RVALID = 1'b0; RDATA = 32'h0;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0000_0413 || out_err !== 1'b0)
            begin bad++; $display("FAIL fetch1 got v=%b pc=%h inst=%h err=%b exp v=1 pc=80000000 inst=00000413 err=0", out_valid, out_pc, out_inst, out_err); end
        total++; if (RREADY !== 1'b0) begin bad++; $display("FAIL rready_drop got=%b exp=0", RREADY); end
    endtask

    task automatic test_out_stall();
        upd_valid = 1'b1; upd_pc = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_inst !== 32'h0000_0413 || out_pc !== 32'h8000_0000 || ARVALID !== 1'b0 || upd_ready !== 1'b0)
                begin bad++; $display("FAIL stall%0d got v=%b inst=%h pc=%h arv=%b ur=%b exp v=1 inst=00000413 pc=80000000 arv=0 ur=0", i, out_valid, out_inst, out_pc, ARVALID, upd_ready); end
        end
        upd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || upd_ready !== 1'b1 || ARVALID !== 1'b0) begin bad++; $display("FAIL wait_state got ov=%b ur=%b arv=%b exp ov=0 ur=1 arv=0", out_valid, upd_ready, ARVALID); end
        upd_valid = 1'b1; upd_pc = 32'h8000_0004;
        tick();
        upd_valid = 1'b0;
        total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0004 || upd_ready !== 1'b0) begin bad++; $display("FAIL next_ar got v=%b a=%h ur=%b exp v=1 a=80000004 ur=0", ARVALID, ARADDR, upd_ready); end
    endtask

    task automatic test_bus_error();
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'hdead_beef; RRESP = 2'b10;
        tick();
        RVALID = 1'b0; RRESP = 2'b00;
        total++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_inst !== 32'h0 || out_pc !== 32'h8000_0004)
            begin bad++; $display("FAIL bus_err got v=%b err=%b inst=%h pc=%h exp v=1 err=1 inst=0 pc=80000004", out_valid, out_err, out_inst, out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h8000_0008;
        tick();
        upd_valid = 1'b0;
        total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0008) begin bad++; $display("FAIL after_err_ar got v=%b a=%h exp v=1 a=80000008", ARVALID, ARADDR); end
    endtask

    task automatic test_back_to_back();
        // Zero-wait slave: RVALID already high during S_AR must not be taken early.
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h0010_0093; RRESP = 2'b00;
        tick();
        ARREADY = 1'b0;
        total++; if (out_valid !== 1'b0 || RREADY !== 1'b1) begin bad++; $display("FAIL fast_mid got ov=%b rr=%b exp ov=0 rr=1", out_valid, RREADY); end
        tick();
        RVALID = 1'b0;
        total++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_0093 || out_err !== 1'b0 || out_pc !== 32'h8000_0008)
            begin bad++; $display("FAIL fast_fetch got v=%b inst=%h err=%b pc=%h exp v=1 inst=00100093 err=0 pc=80000008", out_valid, out_inst, out_err, out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        upd_valid = 1'b1; upd_pc = 32'h8000_0002;
        tick();
        upd_valid = 1'b0;
        ARREADY = 1'b1;
        total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL mis_no_ar got=%b exp=0", ARVALID); end
        tick();
        ARREADY = 1'b0;
        total++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_pc !== 32'h8000_0002 || out_inst !== 32'h0 || ARVALID !== 1'b0 || RREADY !== 1'b0)
            begin bad++; $display("FAIL mis_out got v=%b err=%b pc=%h inst=%h arv=%b rr=%b exp v=1 err=1 pc=80000002 inst=0 arv=0 rr=0", out_valid, out_err, out_pc, out_inst, ARVALID, RREADY); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h8000_0010;
        tick();
        upd_valid = 1'b0;
        total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0010) begin bad++; $display("FAIL mis_recover got v=%b a=%h exp v=1 a=80000010", ARVALID, ARADDR); end
    endtask

    task automatic test_reset_mid();
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        total++; if (RREADY !== 1'b1) begin bad++; $display("FAIL pre_rst_rready got=%b exp=1", RREADY); end
        ARESETn = 1'b0;
        tick();
        total++; if (RREADY !== 1'b0 || ARVALID !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst got rr=%b arv=%b ov=%b exp 0 0 0", RREADY, ARVALID, out_valid); end
        ARESETn = 1'b1;
        RVALID = 1'b1; RDATA = 32'hffff_ffff;
        tick();
        total++; if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0000 || out_valid !== 1'b0 || RREADY !== 1'b0)
            begin bad++; $display("FAIL restart got arv=%b a=%h ov=%b rr=%b exp arv=1 a=80000000 ov=0 rr=0", ARVALID, ARADDR, out_valid, RREADY); end
        tick();
        RVALID = 1'b0;
        total++; if (out_valid !== 1'b0 || ARVALID !== 1'b1) begin bad++; $display("FAIL late_r_ignored got ov=%b arv=%b exp ov=0 arv=1", out_valid, ARVALID); end
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0000_0013;
        tick();
        RVALID = 1'b0;
        total++; if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || out_pc !== 32'h8000_0000)
            begin bad++; $display("FAIL refetch got v=%b inst=%h pc=%h exp v=1 inst=00000013 pc=80000000", out_valid, out_inst, out_pc); end
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_out_stall();
        test_bus_error();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
